// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the CPU requesters, the memory port arbiter and the memory.
// slave: arbiter side; master: requesters plus memory, which drive the arbiter inputs.
interface mem_port_arbiter_if #(
    parameter int WORD_SIZE = 16
);
    logic                 i_req;
    logic [WORD_SIZE-1:0] i_addr;
    logic                 i_ack;
    logic [WORD_SIZE-1:0] i_rdata;

    logic                 d_req;
    logic                 d_we;
    logic [WORD_SIZE-1:0] d_addr;
    logic [WORD_SIZE-1:0] d_wdata;
    logic                 d_ack;
    logic [WORD_SIZE-1:0] d_rdata;

    logic                 mem_req;
    logic                 mem_we;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [WORD_SIZE-1:0] mem_rdata;
    logic                 mem_ack;

    logic                 err;
    logic                 grant_d;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
               err, grant_d
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
               err, grant_d
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction at a time.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break; otherwise the data port wins ties.
module mem_port_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int MAX_WAIT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    // S_IDLE arbitrate | S_BUSY_I fetch in flight | S_BUSY_D data access in flight
    typedef enum logic [1:0] {S_IDLE, S_BUSY_I, S_BUSY_D} state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t               r_state;
    logic [7:0]           r_wait_cnt;
    logic                 r_i_ack;
    logic                 r_d_ack;
    logic                 r_err;
    logic                 r_mem_req;
    logic                 r_mem_we;
    logic                 r_grant_d;
    logic [WORD_SIZE-1:0] r_mem_addr;
    logic [WORD_SIZE-1:0] r_mem_wdata;
    logic [WORD_SIZE-1:0] r_i_rdata;
    logic [WORD_SIZE-1:0] r_d_rdata;

    logic w_i_pend;
    logic w_d_pend;
    logic w_pick_d;
    logic w_expired;

    // A port whose ack is visible this cycle still shows its old request; skip it.
    assign w_i_pend  = bus.i_req & ~r_i_ack;
    assign w_d_pend  = bus.d_req & ~r_d_ack;
    assign w_expired = (r_wait_cnt == WAIT_LIMIT);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_last_d;
    assign w_pick_d = w_d_pend & (~w_i_pend | ~r_last_d);
`else
    assign w_pick_d = w_d_pend;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_err       <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_grant_d   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_d    <= 1'b0;
`endif
        end else begin
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_i_pend | w_d_pend) begin
                        r_mem_req  <= 1'b1;
                        r_wait_cnt <= '0;
                        r_grant_d  <= w_pick_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        r_last_d   <= w_pick_d;
`endif
                        if (w_pick_d) begin
                            r_mem_addr  <= bus.d_addr;
                            r_mem_wdata <= bus.d_wdata;
                            r_mem_we    <= bus.d_we;
                            r_state     <= S_BUSY_D;
                        end else begin
                            r_mem_addr <= bus.i_addr;
                            r_mem_we   <= 1'b0;
                            r_state    <= S_BUSY_I;
                        end
                    end
                end
                S_BUSY_I, S_BUSY_D: begin
                    if (bus.mem_ack || w_expired) begin
                        r_mem_req  <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_grant_d  <= 1'b0;
                        r_wait_cnt <= '0;
                        r_state    <= S_IDLE;
                        if (r_state == S_BUSY_D) begin
                            r_d_ack <= 1'b1;
                        end else begin
                            r_i_ack <= 1'b1;
                        end
                        // A real ack beats a watchdog expiry landing on the same edge.
                        if (bus.mem_ack) begin
                            if (r_state == S_BUSY_D) begin
                                r_d_rdata <= bus.mem_rdata;
                            end else begin
                                r_i_rdata <= bus.mem_rdata;
                            end
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.i_ack     = r_i_ack;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_ack     = r_d_ack;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.err       = r_err;
    assign bus.grant_d   = r_grant_d;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus tie, watchdog and reset sequences.
module tb_mem_port_arbiter;
    localparam int WS = 16;
    localparam int MW = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mem_port_arbiter_if #(.WORD_SIZE(WS)) bus ();

    mem_port_arbiter #(.WORD_SIZE(WS), .MAX_WAIT(MW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          ack_at;
    } vec_t;

    typedef struct {
        bit          is_d;
        logic [15:0] rdata;
        bit          err;
        int          cycles;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] mdl_i_rdata = 16'h0000;
    logic [15:0] mdl_d_rdata = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ctrl"}, 32'({bus.mem_req, bus.mem_we, bus.i_ack, bus.d_ack, bus.err, bus.grant_d}), 32'd0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
        chk({tag, "_i_rdata"}, 32'(bus.i_rdata), 32'd0);
        chk({tag, "_d_rdata"}, 32'(bus.d_rdata), 32'd0);
    endtask

    // Scoreboard entry: which port acks, data it must carry, whether err fires, BUSY edges taken.
    task automatic push_exp(input bit is_d, input int ack_at, input logic [15:0] rdata);
        exp_t e;
        e.is_d = is_d;
        if (ack_at >= 0 && ack_at <= MW) begin
            e.err    = 1'b0;
            e.cycles = ack_at + 1;
            if (is_d) mdl_d_rdata = rdata;
            else      mdl_i_rdata = rdata;
        end else begin
            e.err    = 1'b1;
            e.cycles = MW + 1;
        end
        e.rdata = is_d ? mdl_d_rdata : mdl_i_rdata;
        exp_q.push_back(e);
    endtask

    task automatic grant_chk(input string name, input bit is_d, input bit we, input logic [15:0] addr);
        chk({name, "_ctrl"}, 32'({bus.mem_req, bus.grant_d, bus.mem_we}), 32'({1'b1, is_d, is_d & we}));
        chk({name, "_addr"}, 32'(bus.mem_addr), 32'(addr));
    endtask

    // Entered at the negedge after the grant edge; returns at the negedge of the ack cycle.
    task automatic busy_phase(input int ack_at, input logic [15:0] rdata, input bit we,
                              input logic [15:0] addr, input logic [15:0] wdata);
        int   cyc;
        bit   done;
        exp_t e;
        cyc  = 0;
        done = 1'b0;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q[0];
        while (!done && cyc < 64) begin
            chk("hold_addr", 32'({bus.mem_req, bus.mem_we, bus.mem_addr}), 32'({1'b1, we, addr}));
            if (we) chk("hold_wdata", 32'(bus.mem_wdata), 32'(wdata));
            bus.mem_ack   = (cyc == ack_at);
            bus.mem_rdata = (cyc == ack_at) ? rdata : 16'hDEAD;
            @(negedge clk);
            cyc++;
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 16'hDEAD;
            if (bus.i_ack || bus.d_ack) done = 1'b1;
        end
        void'(exp_q.pop_front());
        if (!done) begin
            chk("ack_timeout", 32'(cyc), 32'(e.cycles));
            return;
        end
        chk("ack_port", 32'({bus.d_ack, bus.i_ack}), e.is_d ? 32'd2 : 32'd1);
        chk("rdata", e.is_d ? 32'(bus.d_rdata) : 32'(bus.i_rdata), 32'(e.rdata));
        chk("err", 32'(bus.err), 32'(e.err));
        chk("busy_edges", 32'(cyc), 32'(e.cycles));
        chk("release", 32'({bus.mem_req, bus.mem_we, bus.grant_d}), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        if (v.is_d) begin
            bus.d_req   = 1'b1;
            bus.d_we    = v.we;
            bus.d_addr  = v.addr;
            bus.d_wdata = v.wdata;
        end else begin
            bus.i_req  = 1'b1;
            bus.i_addr = v.addr;
        end
        push_exp(v.is_d, v.ack_at, v.rdata);
        @(negedge clk);
        grant_chk("vec_grant", v.is_d, v.we, v.addr);
        bus.i_addr  = ~v.addr;
        bus.d_addr  = ~v.addr;
        bus.d_wdata = ~v.wdata;
        bus.d_we    = ~v.we;
        busy_phase(v.ack_at, v.rdata, v.is_d & v.we, v.addr, v.wdata);
        // Request still held through the ack cycle: it must not be granted again.
        @(negedge clk);
        chk("pulse_end", 32'({bus.mem_req, bus.i_ack, bus.d_ack, bus.err}), 32'd0);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
    endtask

    vec_t vecs[7];
    bit   win_d;

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;

        vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA5A5, 2};
        vecs[1] = '{1'b1, 1'b1, 16'h0040, 16'h1234, 16'h0BAD, 3};
        vecs[2] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 16'hBEEF, 0};
        vecs[3] = '{1'b0, 1'b0, 16'h0200, 16'h0000, 16'h1111, -1};
        vecs[4] = '{1'b0, 1'b0, 16'h0300, 16'h0000, 16'h5A5A, MW};
        vecs[5] = '{1'b1, 1'b0, 16'h0400, 16'h0000, 16'h2222, -1};
        vecs[6] = '{1'b1, 1'b1, 16'h0042, 16'hCAFE, 16'h7777, 1};

        @(negedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;

        // Tie straight after reset: data first, then fetch while data's ack is still showing.
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = 16'h1111;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h2222;
        push_exp(1'b1, 0, 16'h3333);
        @(negedge clk);
        grant_chk("tie1_first", 1'b1, 1'b0, 16'h2222);
        busy_phase(0, 16'h3333, 1'b0, 16'h2222, 16'h0000);
        push_exp(1'b0, 1, 16'h4444);
        @(negedge clk);
        grant_chk("tie1_second", 1'b0, 1'b0, 16'h1111);
        bus.d_req = 1'b0;
        busy_phase(1, 16'h4444, 1'b0, 16'h1111, 16'h0000);
        @(negedge clk);
        chk("tie1_idle", 32'({bus.mem_req, bus.i_ack, bus.d_ack}), 32'd0);
        bus.i_req = 1'b0;

        for (int k = 0; k < 7; k++) run_vec(vecs[k]);

        // Tie after a data grant: fixed priority keeps data, round-robin hands it to fetch.
`ifdef MEM_ARB_ROUND_ROBIN_EN
        win_d = 1'b0;
`else
        win_d = 1'b1;
`endif
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = 16'h3000;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h4000;
        push_exp(win_d, 1, 16'h6001);
        @(negedge clk);
        grant_chk("tie2_first", win_d, 1'b0, win_d ? 16'h4000 : 16'h3000);
        busy_phase(1, 16'h6001, 1'b0, win_d ? 16'h4000 : 16'h3000, 16'h0000);
        push_exp(~win_d, 0, 16'h6002);
        @(negedge clk);
        grant_chk("tie2_second", ~win_d, 1'b0, win_d ? 16'h3000 : 16'h4000);
        if (win_d) bus.d_req = 1'b0;
        else       bus.i_req = 1'b0;
        busy_phase(0, 16'h6002, 1'b0, win_d ? 16'h3000 : 16'h4000, 16'h0000);
        @(negedge clk);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        chk("tie2_idle", 32'({bus.mem_req, bus.i_ack, bus.d_ack}), 32'd0);

        // Reset in the second BUSY_D cycle, then a stray memory ack.
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h5555; bus.d_wdata = 16'h6666;
        @(negedge clk);
        grant_chk("rst_grant", 1'b1, 1'b1, 16'h5555);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("mid_reset");
        mdl_i_rdata = 16'h0000;
        mdl_d_rdata = 16'h0000;
        reset       = 1'b0;
        bus.d_req   = 1'b0;
        @(negedge clk);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h9999;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("stray_ack_ctrl", 32'({bus.mem_req, bus.i_ack, bus.d_ack, bus.err}), 32'd0);
        chk("stray_ack_rdata", 32'({bus.i_rdata, bus.d_rdata}), 32'({mdl_i_rdata, mdl_d_rdata}));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
